// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/bubble sequencing for the 5-stage pipeline
// (load-use interlock, E redirect, multi-cycle MUL/DIV, data-memory wait).
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 8,
    parameter int RA_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dec_i_valid,
    input  logic [RA_W-1:0] dec_i_rs1,
    input  logic [RA_W-1:0] dec_i_rs2,
    input  logic            dec_i_rs1_use,
    input  logic            dec_i_rs2_use,
    input  logic            exe_i_valid,
    input  logic [RA_W-1:0] exe_i_rd,
    input  logic            exe_i_is_load,
    input  logic            exe_i_is_mdu,
    input  logic            exe_i_redirect,
    input  logic            mem_i_req,
    input  logic            mem_i_ready,
    output logic            ctrl_o_stall_f,
    output logic            ctrl_o_stall_d,
    output logic            ctrl_o_flush_d,
    output logic            ctrl_o_stall_e,
    output logic            ctrl_o_bubble_e,
    output logic            ctrl_o_stall_m,
    output logic            ctrl_o_bubble_m,
    output logic            ctrl_o_bubble_w,
    output logic [1:0]      ctrl_o_state
);
    typedef enum logic [1:0] {RUN = 2'd0, MDU_WAIT = 2'd1, MEM_WAIT = 2'd2} state_t;

    state_t     state_q, state_d, ret_q, ret_d;
    logic [6:0] cnt_q, cnt_d;
    logic       mem_stall, mdu_go, redirect, load_use;

    assign mem_stall = mem_i_req & !mem_i_ready;
    assign mdu_go    = exe_i_valid & exe_i_is_mdu & (MDU_LAT >= 2);
    assign redirect  = exe_i_valid & exe_i_redirect;
    assign load_use  = exe_i_valid & exe_i_is_load & (exe_i_rd != '0) & dec_i_valid &
                       ((dec_i_rs1_use & (dec_i_rs1 == exe_i_rd)) |
                        (dec_i_rs2_use & (dec_i_rs2 == exe_i_rd)));
    assign ctrl_o_state = rst ? 2'd0 : state_q;

    always_comb begin
        ctrl_o_stall_f  = 1'b0;
        ctrl_o_stall_d  = 1'b0;
        ctrl_o_flush_d  = 1'b0;
        ctrl_o_stall_e  = 1'b0;
        ctrl_o_bubble_e = 1'b0;
        ctrl_o_stall_m  = 1'b0;
        ctrl_o_bubble_m = 1'b0;
        ctrl_o_bubble_w = 1'b0;
        state_d         = state_q;
        ret_d           = ret_q;
        cnt_d           = cnt_q;
        if (rst) begin
            ctrl_o_flush_d  = 1'b1;
            ctrl_o_bubble_e = 1'b1;
        end else if (mem_stall) begin
            {ctrl_o_stall_f, ctrl_o_stall_d, ctrl_o_stall_e, ctrl_o_stall_m} = 4'hf;
            ctrl_o_bubble_w = 1'b1;
            if (state_q != MEM_WAIT) begin
                ret_d   = state_q;
                state_d = MEM_WAIT;
            end
        end else if (state_q == MEM_WAIT) begin
            state_d = ret_q;
        end else if (state_q == MDU_WAIT) begin
            // cnt reaching zero lets the op leave E this cycle
            if (cnt_q != '0) begin
                {ctrl_o_stall_f, ctrl_o_stall_d, ctrl_o_stall_e, ctrl_o_bubble_m} = 4'hf;
                cnt_d = cnt_q - 7'd1;
            end else begin
                state_d = RUN;
            end
        end else if (mdu_go) begin
            {ctrl_o_stall_f, ctrl_o_stall_d, ctrl_o_stall_e, ctrl_o_bubble_m} = 4'hf;
            cnt_d   = 7'(MDU_LAT - 2);
            state_d = MDU_WAIT;
        end else if (redirect) begin
            ctrl_o_flush_d  = 1'b1;
            ctrl_o_bubble_e = 1'b1;
        end else if (load_use) begin
            ctrl_o_stall_f  = 1'b1;
            ctrl_o_stall_d  = 1'b1;
            ctrl_o_bubble_e = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
